// File: rtl/mem_if_pkg.sv
// mem_if_pkg
// Shared definitions for the line-side / memory-side adapters.
//   adapter_state_t : burst adapter FSM states (IDLE, READ, WRITE, DONE)
//   LINE_WIDTH      : cacheline width in bits
//   BEAT_WIDTH      : memory burst beat width in bits
//   BEATS           : beats per cacheline burst
//   OFFSET_WIDTH    : byte-offset bits inside one cacheline
package mem_if_pkg;

  localparam int LINE_WIDTH   = 256;
  localparam int BEAT_WIDTH   = 64;
  localparam int BEATS        = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFSET_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter
// Turns one 256-bit cacheline read/write from the arbiter into a 4-beat,
// 64-bit burst on the physical memory port. Every output is registered,
// so no combinational path runs from line_* to burst_*.
// Ports:
//   clk, rst      : single clock, synchronous active-high reset
//   line_addr     : line byte address (offset bits ignored)
//   line_read     : line read request, held until line_resp
//   line_write    : line write request, held until line_resp
//   line_wdata    : line to write
//   line_rdata    : assembled read line, valid while line_resp
//   line_resp     : one-cycle completion pulse
//   burst_addr    : line-aligned burst address
//   burst_read    : burst read request
//   burst_write   : burst write request
//   burst_wdata   : current write beat
//   burst_rdata   : incoming read beat
//   burst_resp    : one beat moves on every cycle this is high
module cacheline_burst_adapter
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  adapter_state_t        state;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  last_beat;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  unused_offset_bits;

  // The byte offset inside the line never reaches the memory port.
  assign unused_offset_bits = ^line_addr[OFFSET_WIDTH-1:0];

  // Beat bookkeeping: the counter wraps to 0 on the final beat, so it is
  // back at 0 by the time the FSM returns to IDLE.
  always_comb begin
    aligned_addr = {line_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    count_next   = count + 1'b1;
    last_beat    = (count == CNT_W'(BEATS - 1));
  end

  // Adapter FSM with registered outputs. Upstream inputs are only sampled
  // in IDLE, so changes mid-burst and requests still held in DONE are
  // ignored. Read wins when both requests are present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      wline_q     <= '0;
      line_rdata  <= '0;
      line_resp   <= 1'b0;
      burst_addr  <= '0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
      burst_wdata <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (line_read) begin
            burst_addr <= aligned_addr;
            burst_read <= 1'b1;
            state      <= READ;
          end else if (line_write) begin
            burst_addr  <= aligned_addr;
            wline_q     <= line_wdata;
            burst_write <= 1'b1;
            burst_wdata <= line_wdata[BEAT_WIDTH-1:0];
            state       <= WRITE;
          end
        end

        READ: begin
          if (burst_resp) begin
            line_rdata[BEAT_WIDTH*int'(count) +: BEAT_WIDTH] <= burst_rdata;
            count <= count_next;
            if (last_beat) begin
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
              state      <= DONE;
            end
          end
        end

        WRITE: begin
          // burst_wdata is pre-loaded with the next slice so it is already
          // on the port when the memory takes the following beat.
          if (burst_resp) begin
            count <= count_next;
            if (last_beat) begin
              burst_write <= 1'b0;
              burst_wdata <= '0;
              line_resp   <= 1'b1;
              state       <= DONE;
            end else begin
              burst_wdata <= wline_q[BEAT_WIDTH*int'(count_next) +: BEAT_WIDTH];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
